// File: rtl/alu_issue_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_issue_if
// Brief   : Decode/regfile/ALU/writeback bundle seen by the ALU issue stage.
// Revision: 1.0 - initial release
// ============================================================================
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_rd;
    logic [3:0]  in_ra;
    logic [3:0]  in_rb;
    logic        in_use_imm;
    logic [7:0]  in_imm;
    logic [3:0]  rf_ra_addr;
    logic [3:0]  rf_rb_addr;
    logic [15:0] rf_ra_data;
    logic [15:0] rf_rb_data;
    logic [2:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_result;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        mod_zero_err;

    modport master (
        output in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm,
               rf_ra_data, rf_rb_data, alu_result,
        input  in_ready, rf_ra_addr, rf_rb_addr, alu_op, alu_a, alu_b,
               wb_en, wb_addr, wb_data, mod_zero_err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_ra, in_rb, in_use_imm, in_imm,
               rf_ra_data, rf_rb_data, alu_result,
        output in_ready, rf_ra_addr, rf_rb_addr, alu_op, alu_a, alu_b,
               wb_en, wb_addr, wb_data, mod_zero_err
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : alu_issue
// Brief   : Issue stage: hazard stall, result forwarding, writeback tracking.
// Revision: 1.0 - initial release
// ============================================================================
module alu_issue (
    input  logic       clk,
    input  logic       reset,
    alu_issue_if.slave bus
);
    localparam logic [2:0] c_op_nop = 3'b000;
    localparam logic [2:0] c_op_mod = 3'b101;

    logic        w_hit_a;
    logic        w_hit_b;
    logic        w_stall;
    logic        w_accept;
    logic        w_fwd_a;
    logic        w_fwd_b;
    logic [15:0] w_opnd_a;
    logic [15:0] w_opnd_b;

    logic        slot1_valid_q, slot1_valid_d;
    logic [3:0]  slot1_rd_q, slot1_rd_d;
    logic        slot2_valid_q;
    logic [3:0]  slot2_rd_q;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic        mod_zero_err_q, mod_zero_err_d;

    // Slot1 holds a result the ALU has not produced yet, so it can only stall.
    assign w_hit_a  = slot1_valid_q && (slot1_rd_q == bus.in_ra);
    assign w_hit_b  = slot1_valid_q && !bus.in_use_imm && (slot1_rd_q == bus.in_rb);
    assign w_stall  = bus.in_valid && (w_hit_a || w_hit_b);
    assign w_accept = bus.in_valid && !w_stall;

    // Slot2 result sits on alu_result this cycle but is not yet in the regfile.
    assign w_fwd_a  = slot2_valid_q && (slot2_rd_q == bus.in_ra);
    assign w_fwd_b  = slot2_valid_q && (slot2_rd_q == bus.in_rb);
    assign w_opnd_a = w_fwd_a ? bus.alu_result : bus.rf_ra_data;
    assign w_opnd_b = bus.in_use_imm ? {{8{bus.in_imm[7]}}, bus.in_imm}
                                     : (w_fwd_b ? bus.alu_result : bus.rf_rb_data);

    always_comb begin
        alu_op_d       = c_op_nop;
        alu_a_d        = 16'h0000;
        alu_b_d        = 16'h0000;
        slot1_valid_d  = 1'b0;
        slot1_rd_d     = 4'h0;
        mod_zero_err_d = mod_zero_err_q;
        if (w_accept) begin
            alu_op_d      = bus.in_op;
            alu_a_d       = w_opnd_a;
            alu_b_d       = w_opnd_b;
            slot1_valid_d = 1'b1;
            slot1_rd_d    = bus.in_rd;
            if ((bus.in_op == c_op_mod) && (w_opnd_b == 16'h0000)) begin
                mod_zero_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_op_q       <= c_op_nop;
            alu_a_q        <= 16'h0000;
            alu_b_q        <= 16'h0000;
            slot1_valid_q  <= 1'b0;
            slot1_rd_q     <= 4'h0;
            slot2_valid_q  <= 1'b0;
            slot2_rd_q     <= 4'h0;
            mod_zero_err_q <= 1'b0;
        end else begin
            alu_op_q       <= alu_op_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            slot1_valid_q  <= slot1_valid_d;
            slot1_rd_q     <= slot1_rd_d;
            slot2_valid_q  <= slot1_valid_q;
            slot2_rd_q     <= slot1_rd_q;
            mod_zero_err_q <= mod_zero_err_d;
        end
    end

    assign bus.in_ready     = !w_stall;
    assign bus.rf_ra_addr   = bus.in_ra;
    assign bus.rf_rb_addr   = bus.in_rb;
    assign bus.alu_op       = alu_op_q;
    assign bus.alu_a        = alu_a_q;
    assign bus.alu_b        = alu_b_q;
    assign bus.wb_en        = slot2_valid_q;
    assign bus.wb_addr      = slot2_rd_q;
    assign bus.wb_data      = bus.alu_result;
    assign bus.mod_zero_err = mod_zero_err_q;
endmodule
`default_nettype wire
